// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the iterative divider, the instruction
// controller and the PC stall logic.
//   div_state_t : divider FSM states (IDLE, RUN, FIX)
//   DIV_ITERS   : restoring iterations per divide
//   DIV_LATENCY : clock edges from the start edge to the done edge
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_ITERS   = 32;
    localparam int DIV_LATENCY = 33;

endpackage : cpu_pkg

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative restoring divider for MIPS DIV/DIVU. Operands are reduced to
// magnitudes at start, 32 restoring iterations produce |q| and |r|, and a final
// FIX cycle applies signs (or the divide-by-zero override) and loads the
// registered outputs.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request pulse (DIV_ENA | DIVU_ENA), ignored while busy
//   is_signed  1 = DIV, 0 = DIVU, sampled with start
//   dividend   rs operand, sampled with start
//   divisor    rt operand, sampled with start
//   busy       operation in flight (PC hold request)
//   done       one-cycle pulse when q/r/dz are updated
//   q          quotient (to LO), held until the next completion
//   r          remainder (to HI), held until the next completion
//   dz         last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module div_iter
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    // Two's complement negate.
    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
        neg_val = ~x + WIDTH'(1);
    endfunction

    // Magnitude of x; only negative when interpreted as signed.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
        if (sgn && x[WIDTH-1]) begin
            abs_val = neg_val(x);
        end else begin
            abs_val = x;
        end
    endfunction

    div_state_t       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dzf_q, dzf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    // The shifted partial remainder can reach 2*divisor, so it carries one
    // extra bit, plus a sign bit for the trial subtraction.
    logic [WIDTH+1:0] rem_wide_s;
    logic [WIDTH+1:0] trial_s;

    // Next-state and datapath logic for the IDLE/RUN/FIX sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        raw_d      = raw_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dzf_d      = dzf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        q_d        = q_q;
        r_d        = r_q;
        dz_d       = dz_q;
        rem_wide_s = {1'b0, rem_q, quo_q[WIDTH-1]};
        trial_s    = rem_wide_s - {2'b00, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = abs_val(dividend, is_signed);
                    dvs_d   = abs_val(divisor, is_signed);
                    raw_d   = dividend;
                    qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = is_signed & dividend[WIDTH-1];
                    dzf_d   = (divisor == '0);
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Restore by keeping the shifted value when the trial is negative.
                quo_d = {quo_q[WIDTH-2:0], ~trial_s[WIDTH+1]};
                if (trial_s[WIDTH+1]) begin
                    rem_d = rem_wide_s[WIDTH-1:0];
                end else begin
                    rem_d = trial_s[WIDTH-1:0];
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                if (dzf_q) begin
                    q_d = '1;
                    r_d = raw_q;
                end else begin
                    q_d = qneg_q ? neg_val(quo_q) : quo_q;
                    r_d = rneg_q ? neg_val(rem_q) : rem_q;
                end
                dz_d    = dzf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, discarding any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            raw_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            raw_q   <= raw_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzf_q   <= dzf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule : div_iter

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Self-checking bench for div_iter: directed MIPS DIV/DIVU cases, busy/start
// interaction, mid-operation reset and a randomized back-to-back stream, all
// checked against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;

    int n_checks;
    int n_fail;

    div_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: MIPS semantics from plain arithmetic (truncating division).
    function automatic void ref_div(input logic sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] eq, output logic [31:0] er,
                                    output logic edz);
        longint sa, sb;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            eq = 32'(sa / sb);
            er = 32'(sa % sb);
            edz = 1'b0;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
        end
    endfunction

    // Drive a start in the current cycle; returns #1 after the start edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;
    endtask

    // Count edges until done is seen (bounded); also count busy-high samples.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, dz, q, r} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h, expected all 0",
                     busy, done, dz, q, r);
        end
    endtask

    task automatic test_directed();
        logic        sg [8];
        logic [31:0] av [8];
        logic [31:0] bv [8];
        logic [31:0] eq, er;
        logic        edz;
        int lat, bc;
        sg[0]=1'b0; av[0]=32'd100;          bv[0]=32'd7;
        sg[1]=1'b1; av[1]=32'hFFFF_FFF9;    bv[1]=32'd2;
        sg[2]=1'b1; av[2]=32'd7;            bv[2]=32'hFFFF_FFFE;
        sg[3]=1'b1; av[3]=32'h8000_0000;    bv[3]=32'hFFFF_FFFF;
        sg[4]=1'b0; av[4]=32'hFFFF_FFFF;    bv[4]=32'd1;
        sg[5]=1'b1; av[5]=32'h1234_5678;    bv[5]=32'd0;
        sg[6]=1'b0; av[6]=32'hFFFF_FFFF;    bv[6]=32'hFFFF_FFFF;
        sg[7]=1'b0; av[7]=32'hFFFF_FFFE;    bv[7]=32'h8000_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue(sg[i], av[i], bv[i]);
            wait_done(lat, bc);
            ref_div(sg[i], av[i], bv[i], eq, er, edz);
            n_checks++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d edges, expected 33", i, lat);
            end
            n_checks++;
            if (bc !== 33) begin
                n_fail++;
                $display("FAIL dir%0d_busy_cycles: got %0d, expected 33", i, bc);
            end
            n_checks++;
            if (q !== eq || r !== er || dz !== edz) begin
                n_fail++;
                $display("FAIL dir%0d_result: q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                         i, q, r, dz, eq, er, edz);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bc;
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        issue(1'b1, 32'hDEAD_BEEF, 32'd5);
        wait_done(lat, bc);
        n_checks++;
        if (lat !== 23 || q !== 32'd333 || r !== 32'd1 || dz !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_restart: lat=%0d q=%h r=%h, expected lat=23 q=0000014d r=00000001",
                     lat, q, r);
        end
        // New start in the done cycle is accepted; old result stays visible.
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 32'd333 || r !== 32'd1) begin
            n_fail++;
            $display("FAIL done_cycle_start: busy=%b done=%b q=%h r=%h, expected busy=1 done=0 q=0000014d r=00000001",
                     busy, done, q, r);
        end
        wait_done(lat, bc);
        n_checks++;
        if (lat !== 33 || q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL done_cycle_result: lat=%0d q=%h r=%h, expected lat=33 q=fffffff2 r=fffffffe",
                     lat, q, r);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit saw_done;
        @(negedge clk);
        issue(1'b0, 32'd50, 32'd6);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, dz, q, r} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b dz=%b q=%h r=%h, expected all 0",
                     busy, done, dz, q, r);
        end
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: activity seen after reset, expected none");
        end
        @(negedge clk);
        issue(1'b0, 32'd50, 32'd6);
        wait_done(lat, bc);
        n_checks++;
        if (lat !== 33 || q !== 32'd8 || r !== 32'd2 || dz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: lat=%0d q=%h r=%h dz=%b, expected lat=33 q=00000008 r=00000002 dz=0",
                     lat, q, r, dz);
        end
    endtask

    task automatic test_random();
        logic        sg;
        logic [31:0] a, b, eq, er;
        logic        edz;
        int lat, bc, sel;
        @(negedge clk);
        for (int i = 0; i < 1200; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 16));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(1, 31);
                4: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            // Odd ops leave a one-cycle gap after done; even ops start in it.
            if (i % 2 == 1) begin
                @(posedge clk); #1;
            end
            issue(sg, a, b);
            wait_done(lat, bc);
            ref_div(sg, a, b, eq, er, edz);
            n_checks++;
            if (lat !== 33 || q !== eq || r !== er || dz !== edz) begin
                n_fail++;
                $display("FAIL rand%0d s=%b a=%h b=%h: lat=%0d q=%h r=%h dz=%b, expected lat=33 q=%h r=%h dz=%b",
                         i, sg, a, b, lat, q, r, dz, eq, er, edz);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_iter
